s8sp_memsys: RTL and testbench
==============================

S8SP_MEMSYS -- requirements
Module: s8sp_memsys

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low, named `reset`.
REQ-002 `clk` input 1: rising-edge system clock.
REQ-003 `reset` input 1: synchronous, active-low, sampled on `clk` rising edge.
REQ-004 `add` input 8: CPU byte address.
REQ-005 `dat` inout 8: CPU data bus; block drives it only during a valid read, else high-Z.
REQ-006 `rd` input 1: CPU read strobe, active-high.
REQ-007 `wrt` input 1: CPU write strobe, active-high.
REQ-008 `cpu_reset` output 1: active-high reset to s8sp core.
REQ-009 `ld_valid` input 1, `ld_data` input 8, `ld_last` input 1: boot-load byte stream.
REQ-010 `ld_ready` output 1: loader accepts a byte when `ld_valid` and `ld_ready` are both high.
REQ-011 `in_port` input 8: external input port, asynchronous to the bus.
REQ-012 `out_port` output 8: external output port register.
REQ-013 `bus_err` output 1: sticky flag for a strobe conflict (`rd` and `wrt` both high).
REQ-014 `prot_err` output 1: sticky write-protect violation flag.

Function
REQ-015 Storage: 256x8 RAM, indexed by `add` or by the loader pointer.
REQ-016 FSM states and transitions:
- LOAD -> HOLD on an accepted byte with `ld_last`=1, or on an accepted byte at pointer 0xFF.
- HOLD -> RUN after exactly 2 cycles.
- RUN is terminal until `reset`.
REQ-017 LOAD:
- `ld_ready`=1, `cpu_reset`=1.
- Each accepted byte is written to mem[ptr] at the clock edge; 8-bit `ptr` then increments.
- Unloaded locations keep their prior contents.
REQ-018 HOLD: `ld_ready`=0, `cpu_reset`=1.
REQ-019 RUN: `ld_ready`=0, `cpu_reset`=0; `ld_valid` is ignored.
REQ-020 RUN read (`rd`=1, `wrt`=0):
- `dat` is combinationally driven with mem[`add`] (zero-cycle latency).
- Exceptions: `add`=0xFE returns the synchronised `in_port`; `add`=0xFF returns `out_port`.
REQ-021 RUN write (`wrt`=1, `rd`=0) at the rising edge:
- `add`=0xFF loads `out_port`, RAM untouched.
- `add`=0xFE is ignored.
- Otherwise mem[`add`] <= `dat`.
REQ-022 `in_port` passes through a 2-flop synchroniser; a change is visible to reads 2 cycles later.
REQ-023 Strobe conflict (`rd`=`wrt`=1) in RUN:
- No write, `dat` high-Z.
- `bus_err` is set at the next edge and stays set until `reset`.
REQ-024 Strobes are ignored outside RUN; `dat` stays high-Z.
REQ-025 A read and a write to the same address in consecutive cycles SHALL return the newly written value.

Reset
REQ-026 With `reset`=0 at a rising edge, the block SHALL set:
- state=LOAD, ptr=0x00, HOLD counter=0;
- `out_port`=0x00, synchroniser flops=0x00;
- `bus_err`=0, `prot_err`=0, `cpu_reset`=1, `ld_ready`=0 while `reset` is low.
REQ-027 Reset asserted mid-LOAD or mid-RUN SHALL abandon the operation and restart loading at address 0x00; RAM contents are not cleared.

Configuration
REQ-028 Macro S8SP_MEMSYS_WPROT_EN defined:
- In RUN, writes to 0x00-0x7F are discarded and set sticky `prot_err`.
- LOAD writes are unaffected.
REQ-029 Macro S8SP_MEMSYS_WPROT_EN undefined: all RAM addresses are writable in RUN; `prot_err` is tied 0.

Verification
REQ-030 Load 3 bytes (0xA1, 0xB2, 0xC3 with `ld_last` on third) -> `cpu_reset` falls exactly 3 cycles after the last accept; reads of 0x00..0x02 return A1, B2, C3.
REQ-031 Stream 256 bytes with no `ld_last` -> after the byte at 0xFF, state enters HOLD; no further `ld_ready`.
REQ-032 RUN: write 0x5A to 0x90, then read 0x90 -> `dat`=0x5A; write 0x3C to 0xFF -> `out_port`=0x3C, mem[0xFF] unchanged.
REQ-033 RUN: `in_port`=0x77 -> read of 0xFE returns 0x77 from the 2nd cycle after the change, old value before.
REQ-034 RUN: `rd`=`wrt`=1 at `add`=0x10 with `dat` forced 0xEE -> mem[0x10] unchanged, `bus_err`=1 and held.
REQ-035 With S8SP_MEMSYS_WPROT_EN: RUN write 0x99 to 0x20 -> mem[0x20] unchanged, `prot_err`=1. Then `reset` low mid-RUN -> `prot_err`=0, `cpu_reset`=1, `ld_ready`=1 after release.

Source files
------------

// File: rtl/s8sp_memsys.sv
// Boot-loadable 256x8 memory for the s8sp core with memory-mapped I/O ports.
// Optional RUN-time write protection of 0x00-0x7F: define S8SP_MEMSYS_WPROT_EN.
module s8sp_memsys (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] add,
  inout  wire  [7:0] dat,
  input  logic       rd,
  input  logic       wrt,
  output logic       cpu_reset,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  input  logic [7:0] in_port,
  output logic [7:0] out_port,
  output logic       bus_err,
  output logic       prot_err
);

  // state | meaning
  // LOAD  | accept boot bytes into mem[ptr], core held in reset
  // HOLD  | two settling cycles after the final boot byte, core still in reset
  // RUN   | core released, CPU bus active until the next reset
  typedef enum logic [1:0] {ST_LOAD, ST_HOLD, ST_RUN} state_t;

  state_t     state, state_nxt;
  logic       hold_cnt, hold_cnt_nxt;
  logic [7:0] ptr;
  logic [7:0] sync1, sync2;
  logic [7:0] mem [256];

  logic       accept;
  logic       run;
  logic       rd_ok, wr_ok, conflict;
  logic       prot_hit;
  logic       ram_wr;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] rdata;

  assign ld_ready  = reset && (state == ST_LOAD);
  assign cpu_reset = !reset || (state != ST_RUN);
  assign accept    = ld_valid && ld_ready;

  assign run      = reset && (state == ST_RUN);
  assign rd_ok    = run && rd && !wrt;
  assign wr_ok    = run && wrt && !rd;
  assign conflict = run && rd && wrt;

`ifdef S8SP_MEMSYS_WPROT_EN
  assign prot_hit = wr_ok && !add[7];
`else
  assign prot_hit = 1'b0;
`endif

  // 0xFE is the read-only input port, 0xFF the output port register
  assign ram_wr    = wr_ok && (add < 8'hFE) && !prot_hit;
  assign mem_we    = accept || ram_wr;
  assign mem_addr  = accept ? ptr : add;
  assign mem_wdata = accept ? ld_data : dat;

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      ST_LOAD: begin
        if (accept && (ld_last || (ptr == 8'hFF))) begin
          state_nxt    = ST_HOLD;
          hold_cnt_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == 1'b0) state_nxt = ST_RUN;
        else                  hold_cnt_nxt = hold_cnt - 1'b1;
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_LOAD;
      hold_cnt <= 1'b0;
      ptr      <= 8'h00;
      out_port <= 8'h00;
      sync1    <= 8'h00;
      sync2    <= 8'h00;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      sync1    <= in_port;
      sync2    <= sync1;
      if (accept) ptr <= ptr + 8'h01;
      if (wr_ok && (add == 8'hFF)) out_port <= dat;
      if (conflict) bus_err <= 1'b1;
    end
  end

`ifdef S8SP_MEMSYS_WPROT_EN
  always_ff @(posedge clk) begin
    if (!reset)        prot_err <= 1'b0;
    else if (prot_hit) prot_err <= 1'b1;
  end
`else
  assign prot_err = 1'b0;
`endif

  // RAM is deliberately left out of reset so contents survive a reload
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_comb begin
    rdata = mem[add];
    if (add == 8'hFE)      rdata = sync2;
    else if (add == 8'hFF) rdata = out_port;
  end

  assign dat = rd_ok ? rdata : 8'hzz;

endmodule

// File: tb/tb_s8sp_memsys.sv
// Directed bench for s8sp_memsys: boot load, HOLD timing, CPU bus, I/O ports, errors.
// Expectations for write protection follow S8SP_MEMSYS_WPROT_EN.
module tb_s8sp_memsys;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] add;
  wire  [7:0] dat;
  logic       rd, wrt;
  logic       cpu_reset;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic [7:0] in_port;
  logic [7:0] out_port;
  logic       bus_err;
  logic       prot_err;

  logic       drv_en;
  logic [7:0] drv_val;
  int         n_checks = 0;
  int         n_errors = 0;

  assign dat = drv_en ? drv_val : 8'hzz;

  always #5 clk = ~clk;

  s8sp_memsys dut (
    .clk(clk), .reset(reset), .add(add), .dat(dat), .rd(rd), .wrt(wrt),
    .cpu_reset(cpu_reset), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .in_port(in_port),
    .out_port(out_port), .bus_err(bus_err), .prot_err(prot_err)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    add = a; drv_val = d; drv_en = 1'b1; wrt = 1'b1; rd = 1'b0;
    tick();
    wrt = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    add = a; rd = 1'b1; wrt = 1'b0; drv_en = 1'b0;
    #1;
    check(tag, dat, exp);
    rd = 1'b0;
  endtask

  initial begin
    reset = 1'b0; add = 8'h00; rd = 1'b0; wrt = 1'b0;
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    in_port = 8'h00; drv_en = 1'b0; drv_val = 8'h00;
    tick(); tick();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_out_port", out_port, 8'h00);
    check("rst_bus_err", bus_err, 0);
    check("rst_prot_err", prot_err, 0);
    reset = 1'b1;
    #1;
    check("rel_ld_ready", ld_ready, 1);

    // Full 256-byte stream without ld_last: byte i = i ^ 0x5C
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i) ^ 8'h5C;
      if (i == 255) check("stream_ready_ff", ld_ready, 1);
      tick();
    end
    check("stream_hold_ready", ld_ready, 0);
    check("stream_hold_cpu", cpu_reset, 1);
    tick();
    check("stream_hold2_ready", ld_ready, 0);
    check("stream_hold2_cpu", cpu_reset, 1);
    tick();
    check("stream_run_cpu", cpu_reset, 0);
    check("stream_run_ready", ld_ready, 0);
    ld_valid = 1'b0;
    bus_read("stream_rd_00", 8'h00, 8'h5C);
    bus_read("stream_rd_80", 8'h80, 8'hDC);

    // Reload only three bytes; the rest keeps the streamed contents
    reset = 1'b0; tick(); reset = 1'b1;
    #1;
    check("reload_ready", ld_ready, 1);
    ld_valid = 1'b1; ld_data = 8'hA1; tick();
    ld_data = 8'hB2; tick();
    ld_data = 8'hC3; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("hold_c1_cpu", cpu_reset, 1);
    tick();
    check("hold_c2_cpu", cpu_reset, 1);
    tick();
    check("hold_c3_cpu", cpu_reset, 0);
    bus_read("load_rd_00", 8'h00, 8'hA1);
    bus_read("load_rd_01", 8'h01, 8'hB2);
    bus_read("load_rd_02", 8'h02, 8'hC3);
    bus_read("load_rd_03", 8'h03, 8'h5F);

    // CPU writes and the output port
    bus_write(8'h90, 8'h5A);
    bus_read("wr_rd_90", 8'h90, 8'h5A);
    bus_write(8'hFF, 8'h3C);
    check("out_port_3c", out_port, 8'h3C);
    check("mem_ff_kept", dut.mem[8'hFF], 8'hA3);
    bus_read("rd_ff_port", 8'hFF, 8'h3C);
    bus_write(8'hFE, 8'h12);
    check("mem_fe_kept", dut.mem[8'hFE], 8'hA2);

    // Input port synchroniser latency
    add = 8'hFE; rd = 1'b1; in_port = 8'h77;
    #1; check("inp_c0", dat, 8'h00);
    tick(); check("inp_c1", dat, 8'h00);
    tick(); check("inp_c2", dat, 8'h77);
    rd = 1'b0;

    // Strobe conflict
    add = 8'h10; rd = 1'b1; wrt = 1'b1; drv_val = 8'hEE; drv_en = 1'b1;
    #1; check("conf_pre_err", bus_err, 0);
    tick();
    rd = 1'b0; wrt = 1'b0; drv_en = 1'b0;
    check("conf_err_set", bus_err, 1);
    bus_read("conf_mem_10", 8'h10, 8'h4C);
    tick(); tick();
    check("conf_err_held", bus_err, 1);

    // Lower-half write: protected or not depending on build
    bus_write(8'h20, 8'h99);
`ifdef S8SP_MEMSYS_WPROT_EN
    bus_read("wp_mem_20", 8'h20, 8'h7C);
    check("wp_prot_err", prot_err, 1);
`else
    bus_read("wp_mem_20", 8'h20, 8'h99);
    check("wp_prot_err", prot_err, 0);
`endif

    // Reset mid-RUN: flags clear, RAM survives, strobes ignored in HOLD
    reset = 1'b0; tick();
    check("mid_prot_err", prot_err, 0);
    check("mid_bus_err", bus_err, 0);
    check("mid_cpu_reset", cpu_reset, 1);
    check("mid_ld_ready", ld_ready, 0);
    check("mid_out_port", out_port, 8'h00);
    reset = 1'b1;
    #1; check("mid_rel_ready", ld_ready, 1);
    ld_valid = 1'b1; ld_data = 8'h11; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    add = 8'h91; drv_val = 8'h66; drv_en = 1'b1; wrt = 1'b1;
    tick(); tick();
    wrt = 1'b0; drv_en = 1'b0;
    check("mid_run_cpu", cpu_reset, 0);
    bus_read("mid_rd_00", 8'h00, 8'h11);
    bus_read("mid_rd_90", 8'h90, 8'h5A);
    bus_read("hold_wr_ignored", 8'h91, 8'hCD);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
